dsp_mac_sequencer: RTL and testbench

- Controller that runs one DSP48A1-style slice as a streaming multiply-accumulator and returns the dot product of an operand-pair stream.
- A job starts with a start pulse and a length. The block accepts that many (a,b) pairs over a valid/ready handshake and drives the slice's A/B inputs and per-cycle OPMODE. It captures the final P and presents it on a valid/ready result port.
- Sits between a stream source and one slice configured with areg=0, breg=0, a1_reg=1, b1_reg=1, mreg=1, p_reg=1, op_reg=0, carryin_reg=0, carryinsel=OPMODE5.

---
 rtl/dsp_mac_sequencer_if.sv | 32 +++
 rtl/dsp_mac_sequencer.sv | 123 ++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// Port bundle between the MAC sequencer, its operand/result streams and the DSP slice.
// The slave modport is the sequencer's view and the master modport is the environment's view.
interface dsp_mac_sequencer_if #(
    parameter int N  = 18,
    parameter int W  = 48,
    parameter int LW = 16
);
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [N-1:0]  dsp_a;
    logic [N-1:0]  dsp_b;
    logic [7:0]    dsp_opmode;
    logic [W-1:0]  dsp_p;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;

    modport slave (
        input  start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        output busy, in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
    );

    modport master (
        output start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        input  busy, in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1-style slice as a streaming multiply-accumulator and returns
// the unsigned dot product (modulo 2^W) of a length-prefixed operand-pair stream.
module dsp_mac_sequencer #(
    parameter int N     = 18,
    parameter int W     = 48,
    parameter int LW    = 16,
    parameter int LAT_M = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dsp_mac_sequencer_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] OP_ZERO  = 8'h00;
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    logic [1:0]    state;
    logic [LW-1:0] remaining;
    logic          first_flag;
    logic          xfer;
    logic          xfer_last;
    logic          applied_last;
    logic [N-1:0]  a_p0;
    logic [N-1:0]  b_p0;
    logic [W-1:0]  res_q;
    logic          res_vld_q;

    // Tag pipeline: index k is the tag of the pair transferred k+1 edges ago,
    // so index LAT_M lines up with that pair's product at the post-adder.
    logic [LAT_M:0] vld_p;
    logic [LAT_M:0] first_p;
    logic [LAT_M:0] last_p;

    function automatic logic [7:0] tag_opmode(input logic vld, input logic first);
        if (!vld)
            return OP_HOLD;
        else if (first)
            return OP_FIRST;
        else
            return OP_ACC;
    endfunction

    assign xfer      = (state == S_RUN) && bus.in_valid;
    assign xfer_last = xfer && (remaining == LW'(1));

    assign bus.busy       = (state != S_IDLE);
    assign bus.in_ready   = (state == S_RUN);
    assign bus.dsp_a      = a_p0;
    assign bus.dsp_b      = b_p0;
    assign bus.res_valid  = res_vld_q;
    assign bus.res_data   = res_q;
    assign bus.dsp_opmode = (state == S_IDLE) ? OP_ZERO
                                              : tag_opmode(vld_p[LAT_M], first_p[LAT_M]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            remaining    <= '0;
            first_flag   <= 1'b0;
            vld_p        <= '0;
            first_p      <= '0;
            last_p       <= '0;
            applied_last <= 1'b0;
            a_p0         <= '0;
            b_p0         <= '0;
            res_q        <= '0;
            res_vld_q    <= 1'b0;
        end else begin
            vld_p        <= {vld_p[LAT_M-1:0], xfer};
            first_p      <= {first_p[LAT_M-1:0], xfer & first_flag};
            last_p       <= {last_p[LAT_M-1:0], xfer_last};
            // High the cycle P holds the sum including the final product.
            applied_last <= vld_p[LAT_M] & last_p[LAT_M];

            if (xfer) begin
                a_p0       <= bus.in_a;
                b_p0       <= bus.in_b;
                first_flag <= 1'b0;
                remaining  <= remaining - LW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state      <= S_RUN;
                            remaining  <= bus.len;
                            first_flag <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            res_q     <= '0;
                            res_vld_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer_last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (applied_last) begin
                        res_q     <= bus.dsp_p;
                        res_vld_q <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_vld_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice closes the loop, a
// vector table covers the directed jobs and random jobs are checked against a dot-product model.
module tb_dsp_mac_sequencer;
    localparam int N     = 18;
    localparam int W     = 48;
    localparam int LW    = 16;
    localparam int LAT_M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_mac_sequencer_if #(.N(N), .W(W), .LW(LW)) bus ();

    dsp_mac_sequencer #(.N(N), .W(W), .LW(LW), .LAT_M(LAT_M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Slice: A1/B1 register, M register, P register; opmode applied combinationally.
    logic [N-1:0]   a1_q = '0;
    logic [N-1:0]   b1_q = '0;
    logic [2*N-1:0] m_q  = '0;
    logic [W-1:0]   p_q  = '0;
    always @(posedge clk) begin
        a1_q <= bus.dsp_a;
        b1_q <= bus.dsp_b;
        m_q  <= a1_q * b1_q;
        p_q  <= ((bus.dsp_opmode[3:2] == 2'b10) ? p_q : '0)
              + ((bus.dsp_opmode[1:0] == 2'b01) ? W'(m_q) : '0);
    end
    assign bus.dsp_p = p_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;
    int last_xfer = 0;
    int xfer_kind [int];
    logic [N-1:0] qa [$];
    logic [N-1:0] qb [$];

    typedef struct {
        int             len;
        int             gap;
        int             stall;
        bit             poke_start;
        logic [3:0][N-1:0] a;
        logic [3:0][N-1:0] b;
        logic [W-1:0]   exp_res;
        string          name;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
    endtask

    // Every wait goes through here; while busy, the opmode is checked against the
    // transfer that happened LAT_M edges earlier.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (mon_en && bus.busy === 1'b1) begin
            if (xfer_kind.exists(cyc - LAT_M))
                e = (xfer_kind[cyc - LAT_M] == 1) ? 8'h01 : 8'h09;
            else
                e = 8'h08;
            chk("opmode", 64'(bus.dsp_opmode), 64'(e));
        end
    endtask

    task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b, input bit first, input int gap);
        int n;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout("in_ready_wait");
        tick();
        last_xfer = cyc;
        xfer_kind[cyc] = first ? 1 : 2;
        bus.in_valid = 1'b0;
        bus.in_a     = N'($urandom);
        bus.in_b     = N'($urandom);
    endtask

    function automatic logic [W-1:0] ref_dot(input int n);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++)
            acc = acc + W'(qa[i]) * W'(qb[i]);
        return acc;
    endfunction

    task automatic run_job(input int len, input int gap, input int stall, input bit poke_start,
                           input logic [W-1:0] exp, input string name);
        int n;
        int target;
        int g;
        bus.start = 1'b1;
        bus.len   = LW'(len);
        tick();
        bus.start = 1'b0;
        bus.len   = LW'($urandom);
        target = cyc;
        if (len == 0) chk({name, "_in_ready_len0"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < len; i++) begin
            g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
            send_pair(qa[i], qb[i], i == 0, g);
        end
        if (len != 0) begin
            target = last_xfer + LAT_M + 2;
            chk({name, "_in_ready_drain"}, 64'(bus.in_ready), 64'd0);
        end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout({name, "_res_valid_wait"});
        chk({name, "_latency"}, 64'(cyc), 64'(target));
        chk({name, "_res_data"}, 64'(bus.res_data), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            if (poke_start && i == 2) begin
                bus.start = 1'b1;
                bus.len   = 16'd5;
            end
            tick();
            bus.start = 1'b0;
            chk({name, "_stall_valid"}, 64'(bus.res_valid), 64'd1);
            chk({name, "_stall_data"}, 64'(bus.res_data), 64'(exp));
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({name, "_valid_after"}, 64'(bus.res_valid), 64'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        vecs[0] = '{len: 4, gap: 0, stall: 0, poke_start: 1'b0,
                    a: {18'd4, 18'd3, 18'd2, 18'd1}, b: {18'd8, 18'd7, 18'd6, 18'd5},
                    exp_res: 48'd70, name: "dot4"};
        vecs[1] = '{len: 4, gap: 3, stall: 0, poke_start: 1'b0,
                    a: {18'd4, 18'd3, 18'd2, 18'd1}, b: {18'd8, 18'd7, 18'd6, 18'd5},
                    exp_res: 48'd70, name: "dot4_bubbles"};
        vecs[2] = '{len: 0, gap: 0, stall: 0, poke_start: 1'b0,
                    a: '0, b: '0, exp_res: 48'd0, name: "len0"};
        vecs[3] = '{len: 4, gap: 0, stall: 10, poke_start: 1'b1,
                    a: {18'd4, 18'd3, 18'd2, 18'd1}, b: {18'd8, 18'd7, 18'd6, 18'd5},
                    exp_res: 48'd70, name: "done_stall"};
        vecs[4] = '{len: 1, gap: 0, stall: 0, poke_start: 1'b0,
                    a: {54'd0, 18'h20000}, b: {54'd0, 18'h20000},
                    exp_res: 48'h4_0000_0000, name: "b2b_single"};
        vecs[5] = '{len: 3, gap: 0, stall: 0, poke_start: 1'b0,
                    a: {18'd0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
                    b: {18'd0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
                    exp_res: 48'd3 * 48'h3FFFF * 48'h3FFFF, name: "b2b_max"};

        repeat (3) tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_dsp_a", 64'(bus.dsp_a), 64'd0);
        chk("rst_dsp_b", 64'(bus.dsp_b), 64'd0);
        chk("rst_opmode", 64'(bus.dsp_opmode), 64'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                qa.push_back(vecs[v].a[i]);
                qb.push_back(vecs[v].b[i]);
            end
            run_job(vecs[v].len, vecs[v].gap, vecs[v].stall, vecs[v].poke_start,
                    vecs[v].exp_res, vecs[v].name);
        end

        // Reset in the middle of a job abandons it.
        bus.start = 1'b1;
        bus.len   = 16'd4;
        tick();
        bus.start = 1'b0;
        send_pair(18'd1, 18'd5, 1'b1, 0);
        send_pair(18'd2, 18'd6, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        xfer_kind.delete();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("midrst_opmode", 64'(bus.dsp_opmode), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        qa = '{18'd3, 18'd4};
        qb = '{18'd3, 18'd4};
        run_job(2, 0, 0, 1'b0, 48'd25, "after_rst");

        // Random jobs against the dot-product model.
        for (int j = 0; j < 25; j++) begin
            int len;
            len = int'($urandom_range(1, 8));
            qa.delete();
            qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back(N'($urandom));
                qb.push_back(N'($urandom));
            end
            run_job(len, -1, int'($urandom_range(0, 3)), 1'b0, ref_dot(len), "rand");
        end

        // Long job of full-scale products so the accumulator wraps past 2^W.
        qa.delete();
        qb.delete();
        for (int i = 0; i < 4100; i++) begin
            qa.push_back(18'h3FFFF);
            qb.push_back(18'h3FFFF);
        end
        run_job(4100, 0, 1, 1'b0, ref_dot(4100), "wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
